// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the segmented pipelined adder.
//   op_e        : add/sub operation encoding (OP_ADD=0, OP_SUB=1)
//   DEF_WIDTH   : default operand/result width
//   DEF_SEG     : default segment width handled by one pipeline stage
//   first_carry : carry injected into stage 0 (depends on sub and cin only)
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG   = 8;

    // Subtraction is a + ~b + 1, so the incoming carry is forced to 1 and
    // the user carry-in is ignored.
    function automatic logic first_carry(input logic sub, input logic cin);
        return (op_e'(sub) == OP_SUB) ? 1'b1 : cin;
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// pipe_adder_if: valid/ready operand and result bus of pipe_adder.
//   Input side : in_valid, in_ready, a, b, cin, sub
//   Output side: out_valid, out_ready, s, cout, zero, neg, ovf
//   master modport: the producer/consumer (testbench or surrounding logic)
//   slave modport : the adder itself
interface pipe_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, zero, neg, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, zero, neg, ovf
    );

endinterface

// File: rtl/seg_add.sv
// seg_add: combinational SEG-bit adder slice.
//   a, b : segment operands
//   cin  : carry into bit 0
//   s    : segment sum
//   cout : carry out of bit SEG-1
//   cmsb : carry into bit SEG-1 (used for signed overflow on the top slice)
module seg_add
    import adder_pkg::*;
#(
    parameter int SEG = DEF_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           cmsb
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out of the
    // MSB sum bit without a second adder chain.
    assign cmsb = s[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined adder/subtractor, one SEG-bit slice per stage.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : pipe_adder_if.slave (operands in, result + flags out, valid/ready
//          on both sides)
// Stage k adds segment k using the carry registered by stage k-1. Register
// set k holds the partial result, carry, and the full operand copies (skew
// registers); register set STAGES-1 is the output register, so latency is
// exactly STAGES cycles. The whole pipe shifts only when the output is empty
// or being consumed, otherwise everything holds (full stall).
// Optional macro PIPE_ADDER_FLAGS_EN: enables registered zero/neg/ovf flags;
// without it the flags are constant 0.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input logic         clk,
    input logic         rst,
    pipe_adder_if.slave bus
);

    localparam int STAGES = WIDTH / SEG;

    logic                advance;
    logic [STAGES-1:0]   valid_reg;
    logic [STAGES-1:0]   valid_next;
    logic [STAGES-1:0]   carry_reg;
    logic [STAGES-1:0]   carry_next;
    logic [STAGES-1:0]   cmsb_w;
    logic [WIDTH-1:0]    a_reg    [STAGES];
    logic [WIDTH-1:0]    a_next   [STAGES];
    logic [WIDTH-1:0]    b_reg    [STAGES];
    logic [WIDTH-1:0]    b_next   [STAGES];
    logic [WIDTH-1:0]    sum_reg  [STAGES];
    logic [WIDTH-1:0]    sum_next [STAGES];

    assign advance      = !valid_reg[STAGES-1] || bus.out_ready;
    assign bus.in_ready = advance;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] src_a;
            logic [WIDTH-1:0] src_b;
            logic [WIDTH-1:0] src_s;
            logic             src_c;
            logic             src_v;
            logic [SEG-1:0]   seg_s;
            logic             seg_c;
            logic [WIDTH-1:0] stage_sum;

            if (gi == 0) begin : g_first
                // b is inverted once on entry; later stages just add.
                assign src_a = bus.a;
                assign src_b = (op_e'(bus.sub) == OP_SUB) ? ~bus.b : bus.b;
                assign src_c = first_carry(bus.sub, bus.cin);
                assign src_s = '0;
                assign src_v = bus.in_valid;
            end else begin : g_next
                assign src_a = a_reg[gi-1];
                assign src_b = b_reg[gi-1];
                assign src_c = carry_reg[gi-1];
                assign src_s = sum_reg[gi-1];
                assign src_v = valid_reg[gi-1];
            end

            seg_add #(.SEG(SEG)) u_seg (
                .a    (src_a[gi*SEG +: SEG]),
                .b    (src_b[gi*SEG +: SEG]),
                .cin  (src_c),
                .s    (seg_s),
                .cout (seg_c),
                .cmsb (cmsb_w[gi])
            );

            // Keep the segments already produced, drop in this stage's slice.
            always_comb begin
                stage_sum                  = src_s;
                stage_sum[gi*SEG +: SEG]   = seg_s;
            end

            assign sum_next[gi]   = stage_sum;
            assign carry_next[gi] = seg_c;
            assign valid_next[gi] = src_v;
            assign a_next[gi]     = src_a;
            assign b_next[gi]     = src_b;
        end
    endgenerate

    // Control and result registers (reset) .
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            carry_reg <= '0;
            for (int k = 0; k < STAGES; k++) begin
                sum_reg[k] <= '0;
            end
        end else if (advance) begin
            valid_reg <= valid_next;
            carry_reg <= carry_next;
            for (int k = 0; k < STAGES; k++) begin
                sum_reg[k] <= sum_next[k];
            end
        end
    end

    // Operand skew registers: never reset, only observed through valid stages.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_reg[k] <= a_next[k];
                b_reg[k] <= b_next[k];
            end
        end
    end

    assign bus.out_valid = valid_reg[STAGES-1];
    assign bus.s         = sum_reg[STAGES-1];
    assign bus.cout      = carry_reg[STAGES-1];

`ifdef PIPE_ADDER_FLAGS_EN
    logic zero_reg;
    logic neg_reg;
    logic ovf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_reg <= 1'b0;
            neg_reg  <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (advance) begin
            zero_reg <= (sum_next[STAGES-1] == '0);
            neg_reg  <= sum_next[STAGES-1][WIDTH-1];
            ovf_reg  <= cmsb_w[STAGES-1] ^ carry_next[STAGES-1];
        end
    end

    assign bus.zero = zero_reg;
    assign bus.neg  = neg_reg;
    assign bus.ovf  = ovf_reg;
`else
    assign bus.zero = 1'b0;
    assign bus.neg  = 1'b0;
    assign bus.ovf  = 1'b0;
`endif

    // The last stage's operand copies and the lower stages' MSB carries have
    // no consumer; fold them into one sink so they are visibly intentional.
    logic unused_sink;
    assign unused_sink = ^{cmsb_w, a_reg[STAGES-1], b_reg[STAGES-1]};

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: self-checking bench for pipe_adder (WIDTH=32, SEG=8).
// Reference model is plain wide arithmetic; expected results are queued on
// input transfer and compared on output transfer.
module tb_pipe_adder;
    import adder_pkg::*;

    localparam int WIDTH  = 32;
    localparam int SEG    = 8;
    localparam int STAGES = WIDTH / SEG;
`ifdef PIPE_ADDER_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_adder_if #(.WIDTH(WIDTH)) bus ();

    pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             zero;
        logic             neg;
        logic             ovf;
        int               cyc;
    } exp_t;

    exp_t q[$];
    exp_t pending;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    int   n_out    = 0;
    bit   lat_chk  = 1'b0;
    bit   in_fired = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        longint      ua, ub, tot;
        longint      sa, sb, sres;
        ua  = longint'(a);
        ub  = longint'(b);
        if (sub) begin
            tot = ua + ((64'd1 << WIDTH) - 1 - ub) + 1;
        end else begin
            tot = ua + ub + longint'(cin);
        end
        e.s    = tot[WIDTH-1:0];
        e.cout = tot[WIDTH];
        // Signed overflow: true signed result outside the WIDTH-bit range.
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        sres = sub ? (sa - sb) : (sa + sb + longint'(cin));
        e.ovf  = FLAGS && ((sres > 64'sh7FFFFFFF) || (sres < -64'sh80000000));
        e.zero = FLAGS && (e.s == '0);
        e.neg  = FLAGS && e.s[WIDTH-1];
        e.cyc  = 0;
        return e;
    endfunction

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        pending      = model(a, b, cin, sub);
    endtask

    task automatic drive_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic cin, input logic sub,
                             input logic [WIDTH-1:0] s, input logic cout,
                             input logic zero, input logic neg, input logic ovf);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        pending.s    = s;
        pending.cout = cout;
        pending.zero = FLAGS && zero;
        pending.neg  = FLAGS && neg;
        pending.ovf  = FLAGS && ovf;
        pending.cyc  = 0;
    endtask

    // One clock: check/record transfers away from the edge, then advance.
    task automatic step();
        exp_t e;
        #1;
        in_fired = 1'b0;
        if (!rst) begin
            chk("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.out_valid) begin
                chk("no_stale_or_extra", q.size() == 0, 0);
                if (bus.out_ready && q.size() != 0) begin
                    e = q.pop_front();
                    chk("s", bus.s, e.s);
                    chk("cout", bus.cout, e.cout);
                    chk("zero", bus.zero, e.zero);
                    chk("neg", bus.neg, e.neg);
                    chk("ovf", bus.ovf, e.ovf);
                    if (lat_chk) chk("latency", cyc - e.cyc, STAGES);
                    $display("out  cyc=%0d s=%08h cout=%0b z=%0b n=%0b v=%0b",
                             cyc, bus.s, bus.cout, bus.zero, bus.neg, bus.ovf);
                    n_out++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                pending.cyc = cyc;
                q.push_back(pending);
                in_fired = 1'b1;
                $display("in   cyc=%0d a=%08h b=%08h cin=%0b sub=%0b",
                         cyc, bus.a, bus.b, bus.cin, bus.sub);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int limit);
        bus.in_valid = 1'b0;
        for (int i = 0; i < limit && q.size() != 0; i++) step();
        chk("drain_empty", q.size(), 0);
    endtask

    logic [WIDTH-1:0] snap_s;
    logic             snap_c, snap_z, snap_n, snap_v;
    int               base;

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        pending       = model('0, '0, 1'b0, 1'b0);

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_s", bus.s, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_zero", bus.zero, 0);
        chk("rst_neg", bus.neg, 0);
        chk("rst_ovf", bus.ovf, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        // Directed corner cases, exact latency expected
        lat_chk = 1'b1;
        drive_exp(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); drain(10);
        drive_exp(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1);
        step(); drain(10);
        drive_exp(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        step(); drain(10);
        drive_exp(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        step(); drain(10);
        drive_exp(32'h00000001, 32'h00000001, 1'b1, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); drain(10);
        drive_exp(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); drain(10);

        // Back-to-back random, one result per cycle
        base = n_out;
        for (int i = 0; i < 100; i++) begin
            drive($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
            step();
        end
        drain(20);
        chk("b2b_count", n_out - base, 100);

        // Random bubbles and backpressure, operands held until accepted
        lat_chk = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!bus.in_valid || in_fired) begin
                if ($urandom_range(3) != 0)
                    drive($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
                else
                    bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(3) != 0);
            step();
        end
        bus.out_ready = 1'b1;
        drain(20);

        // Full stall for 6 cycles
        base = n_out;
        for (int i = 0; i < 4; i++) begin
            drive($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
            step();
        end
        bus.out_ready = 1'b0;
        drive($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
        #1;
        chk("stall_full", bus.out_valid, 1);
        snap_s = bus.s;
        snap_c = bus.cout;
        snap_z = bus.zero;
        snap_n = bus.neg;
        snap_v = bus.ovf;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_s", bus.s, snap_s);
            chk("stall_cout", bus.cout, snap_c);
            chk("stall_flags", {bus.zero, bus.neg, bus.ovf}, {snap_z, snap_n, snap_v});
        end
        bus.out_ready = 1'b1;
        step();
        drain(20);
        chk("stall_count", n_out - base, 5);

        // Reset with 3 results in flight
        base = n_out;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
            step();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        q.delete();
        rst = 1'b0;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_s", bus.s, 0);
        for (int i = 0; i < 8; i++) step();
        chk("midrst_no_output", n_out - base, 0);

        // Pipeline usable again after reset
        lat_chk = 1'b1;
        drive($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
        step();
        drain(10);
        chk("post_rst_count", n_out - base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, 32, operand and result width in bits; SHALL be a multiple of SEG.
REQ-002 Parameter SEG, 8, segment width added per pipeline stage; STAGES = WIDTH/SEG, and STAGES >= 1.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port in_valid  input  1  operand set offered this cycle.
REQ-006 Port in_ready  output  1  pipeline accepts an operand set this cycle.
REQ-007 Port a, b  input  WIDTH each  operands.
REQ-008 Port cin  input  1  carry-in; ignored when sub=1.
REQ-009 Port sub  input  1  0 computes a+b+cin; 1 computes a-b as a+~b+1.
REQ-010 Port out_valid  output  1  result held on s/cout/flags.
REQ-011 Port out_ready  input  1  consumer accepts the result this cycle.
REQ-012 Port s  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-013 Port cout  output  1  carry out of bit WIDTH-1; for sub, 1 means no borrow.
REQ-014 Ports zero, neg, ovf  output  1 each  result==0, s[WIDTH-1], signed overflow.

Function
REQ-015 Transfer in SHALL occur on in_valid && in_ready; transfer out SHALL occur on out_valid && out_ready.
REQ-016 Stage k (0..STAGES-1) SHALL add segment k of both operands plus the carry registered by stage k-1 (stage 0 uses cin or, when sub=1, 1).
REQ-017 Operand segments not yet consumed and result segments already produced SHALL be carried forward in skew registers alongside each stage's valid bit.
REQ-018 Latency SHALL be exactly STAGES cycles from input transfer to out_valid when out_ready is held at 1.
REQ-019 advance = !out_valid || out_ready; in_ready SHALL equal advance, and all stages SHALL shift together only when advance=1.
REQ-020 When advance=0, every stage register and the output SHALL hold unchanged (full stall, no data loss).
REQ-021 Throughput SHALL be one result per cycle with in_valid=1 and out_ready=1 continuously.
REQ-022 Bubbles (in_valid=0 while advance=1) SHALL propagate as invalid stages without affecting neighbouring results.
REQ-023 s, cout and flags SHALL be stable whenever out_valid=1 and out_ready=0.
REQ-024 ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-025 The first-stage carry-in SHALL be a function of sub and cin only; STAGES=1 SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-026 rst=1 at a clock edge SHALL clear all stage valid bits, out_valid, s, cout, zero, neg and ovf to 0.
REQ-027 rst mid-operation SHALL discard all in-flight results; in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-028 Datapath skew registers need no reset; their contents SHALL never reach s while the corresponding valid bit is 0.

Configuration
REQ-029 Macro PIPE_ADDER_FLAGS_EN defined: zero, neg and ovf SHALL be computed and registered with the result.
REQ-030 PIPE_ADDER_FLAGS_EN undefined: zero, neg and ovf SHALL be tied to 0 with no flag logic; s and cout are unaffected.

Structure
REQ-031 Shared package adder_pkg SHALL hold the add/sub op enum (OP_ADD=0, OP_SUB=1) and default WIDTH/SEG constants.
REQ-032 Sub-module seg_add (combinational, SEG-bit a, b, cin -> s, cout, plus carry into MSB) SHALL be instantiated once per stage.

Verification (WIDTH=32, SEG=8, STAGES=4)
REQ-033 a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> after 4 cycles s=0x00000000, cout=1, zero=1, ovf=0.
REQ-034 a=0x7FFFFFFF, b=0x00000001, sub=0 -> s=0x80000000, cout=0, neg=1, ovf=1; a=5, b=7, sub=1 -> s=0xFFFFFFFE, cout=0.
REQ-035 Back-to-back 100 random operand sets, out_ready=1 -> 100 results in order, one per cycle, first at cycle 4.
REQ-036 out_ready=0 for 6 cycles with pipeline full -> in_ready=0, outputs frozen, no result lost or duplicated after release.
REQ-037 rst asserted with 3 results in flight -> out_valid=0 next cycle, no stale result ever emitted.
REQ-038 Build without PIPE_ADDER_FLAGS_EN, rerun REQ-034 -> identical s/cout, zero=neg=ovf=0.
